microwave_timer: RTL and testbench

- BCD countdown timer for the microwave controller; the counterpart of on_off_logic.
- Consumes the magnetron-on level (mag_on, the output of the set/reset latch driven by on_off_logic).
- Produces timer_done, which feeds back into on_off_logic to reset that latch.
- Also holds the keypad-entered cook time (M:SS) and drives the display digits.

---
 rtl/microwave_timer.sv | 159 +++++++++++++++
 tb/tb_microwave_timer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// microwave_timer: BCD M:SS cook-time register and countdown driven by the magnetron-on level.
// Optional done beep is built only when `TIMER_BEEP_EN is defined; otherwise beep is tied low.
module microwave_timer #(
  parameter int CLK_PER_SEC = 1000,
  parameter int BEEP_CYCLES = 500
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       beep
);

  localparam int              PS_W   = $clog2(CLK_PER_SEC);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_SEC - 1);

  if (CLK_PER_SEC < 2) begin : g_cps_check
    $error("microwave_timer: CLK_PER_SEC must be >= 2");
  end
  if (BEEP_CYCLES < 1) begin : g_beep_check
    $error("microwave_timer: BEEP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [11:0]     tm, tm_nxt, tm_dec;
  logic [PS_W-1:0] ps, ps_nxt;
  logic            digit_ok;
  logic            tm_zero;

  // One-second BCD decrement; sec_tens entered as 6..9 simply counts down from there.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [3:0] m;
    logic [3:0] st;
    logic [3:0] so;
    m  = t[11:8];
    st = t[7:4];
    so = t[3:0];
    if (so == 4'd0) begin
      so = 4'd9;
      if (st == 4'd0) begin
        st = 4'd5;
        m  = m - 4'd1;
      end else begin
        st = st - 4'd1;
      end
    end else begin
      so = so - 4'd1;
    end
    return {m, st, so};
  endfunction

  assign digit_ok = (digit <= 4'd9);
  assign tm_zero  = (tm == 12'h000);
  assign tm_dec   = bcd_dec(tm);

  always_comb begin
    state_nxt = state;
    tm_nxt    = tm;
    ps_nxt    = ps;
    case (state)
      IDLE: begin
        // Start request wins over a simultaneous keypad strobe.
        if (mag_on) begin
          ps_nxt    = '0;
          state_nxt = tm_zero ? DONE : COUNT;
        end else if (load && digit_ok) begin
          tm_nxt = {tm[7:0], digit};
        end
      end
      COUNT: begin
        if (mag_on) begin
          if (ps == PS_MAX) begin
            ps_nxt = '0;
            tm_nxt = tm_dec;
            if (tm_dec == 12'h000) begin
              state_nxt = DONE;
            end
          end else begin
            ps_nxt = ps + PS_W'(1);
          end
        end
      end
      DONE: begin
        if (load && digit_ok) begin
          tm_nxt    = {tm[7:0], digit};
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        tm_nxt    = '0;
        ps_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state <= IDLE;
      tm    <= '0;
      ps    <= '0;
    end else begin
      state <= state_nxt;
      tm    <= tm_nxt;
      ps    <= ps_nxt;
    end
  end

  assign min_ones   = tm[11:8];
  assign sec_tens   = tm[7:4];
  assign sec_ones   = tm[3:0];
  assign timer_done = (state == DONE);

`ifdef TIMER_BEEP_EN
  localparam int BC_W = $clog2(BEEP_CYCLES + 1);

  logic            beep_q;
  logic [BC_W-1:0] bcnt;
  logic            done_entry;

  assign done_entry = (state != DONE) && (state_nxt == DONE);

  // bcnt holds the number of beep cycles still owed after the current one.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      beep_q <= 1'b0;
      bcnt   <= '0;
    end else if (done_entry) begin
      beep_q <= 1'b1;
      bcnt   <= BC_W'(BEEP_CYCLES - 1);
    end else if (state_nxt != DONE) begin
      beep_q <= 1'b0;
      bcnt   <= '0;
    end else if (beep_q) begin
      if (bcnt == '0) begin
        beep_q <= 1'b0;
      end else begin
        bcnt <= bcnt - BC_W'(1);
      end
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer (CLK_PER_SEC=4, BEEP_CYCLES=3) using an expectation queue.
module tb_microwave_timer;

  localparam int CPS = 4;
  localparam int BC  = 3;
`ifdef TIMER_BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       clearn = 1'b0;
  logic       load   = 1'b0;
  logic [3:0] digit  = 4'd0;
  logic       mag_on = 1'b0;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       timer_done, beep;

  typedef struct packed {
    logic [15:0] step;
    logic [11:0] t;
    logic        done;
    logic        bp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  microwave_timer #(.CLK_PER_SEC(CPS), .BEEP_CYCLES(BC)) dut (
    .clk(clk), .clearn(clearn), .load(load), .digit(digit), .mag_on(mag_on),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(int step, logic [11:0] t, logic done, logic bp);
    exp_t x;
    x.step = 16'(step);
    x.t    = t;
    x.done = done;
    x.bp   = bp;
    return x;
  endfunction

  // Standard M:SS rendering of a number of seconds (0..599).
  function automatic logic [11:0] to_bcd(int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic test_reset();
    exp_t e;
    clearn = 1'b0; load = 1'b0; mag_on = 1'b0; digit = 4'd0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(i, 12'h000, 1'b0, 1'b0));
      tick();
      if (i == 1) clearn = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL reset step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
    end
  endtask

  task automatic test_entry();
    exp_t e;
    logic [3:0]  ds [5];
    logic [11:0] ex [5];
    ds[0] = 4'd1; ds[1] = 4'd0; ds[2] = 4'd5; ds[3] = 4'd12; ds[4] = 4'd10;
    ex[0] = 12'h001; ex[1] = 12'h010; ex[2] = 12'h105; ex[3] = 12'h105; ex[4] = 12'h105;
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; digit = ds[i]; mag_on = 1'b0;
      sb.push_back(mk(i, ex[i], 1'b0, 1'b0));
      tick();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL entry step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
    end
  endtask

  // 1:00 down to 0:00; load pulses at entry and mid-count must be ignored.
  task automatic test_countdown();
    exp_t e;
    int   k;
    for (int i = 0; i < 3 + 246; i++) begin
      if (i < 3) begin
        load = 1'b1; mag_on = 1'b0;
        digit = (i == 0) ? 4'd1 : 4'd0;
        sb.push_back(mk(i, (i == 0) ? 12'h051 : (i == 1) ? 12'h510 : 12'h100, 1'b0, 1'b0));
      end else begin
        k = i - 3;
        mag_on = 1'b1;
        load   = (k == 0) || (k == 10);
        digit  = 4'd7;
        sb.push_back(mk(i, to_bcd((k >= 240) ? 0 : 60 - k / CPS), k >= 240,
                        BEEP_ON && k >= 240 && k < 240 + BC));
      end
      tick();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL countdown step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
    end
  endtask

  // Leave DONE, run 0:03 to 0:02 with prescaler at 2, pause 10 cycles, then 0:01 two cycles later.
  task automatic test_pause();
    exp_t        e;
    logic [11:0] t;
    logic        d;
    for (int i = 0; i < 22; i++) begin
      load = 1'b0; mag_on = 1'b0; digit = 4'd0; d = 1'b0; t = 12'h002;
      if (i < 3) begin
        load  = 1'b1;
        digit = (i == 0) ? 4'd12 : (i == 1) ? 4'd0 : 4'd3;
        t     = (i == 2) ? 12'h003 : 12'h000;
        d     = (i == 0);
      end else if (i < 10) begin
        mag_on = 1'b1;
        t      = (i - 2 <= 4) ? 12'h003 : 12'h002;
      end else if (i < 20) begin
        load  = (i == 14);
        digit = 4'd4;
      end else begin
        mag_on = 1'b1;
        t      = (i == 20) ? 12'h002 : 12'h001;
      end
      sb.push_back(mk(i, t, d, 1'b0));
      tick();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL pause step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
    end
    mag_on = 1'b0;
  endtask

  // Async clear out of a paused count, zero start into DONE, exit on load 7.
  task automatic test_zero_start();
    exp_t e;
    logic async;
    for (int i = 0; i < 4; i++) begin
      async = (i == 0);
      load  = (i == 3);
      digit = 4'd7;
      mag_on = (i == 1) || (i == 2);
      if (i == 0)      sb.push_back(mk(i, 12'h000, 1'b0, 1'b0));
      else if (i < 3)  sb.push_back(mk(i, 12'h000, 1'b1, BEEP_ON));
      else             sb.push_back(mk(i, 12'h007, 1'b0, 1'b0));
      if (async) begin
        clearn = 1'b0;
        #2;
      end else begin
        tick();
      end
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL zero_start step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
      if (async) begin
        tick();
        clearn = 1'b1;
      end
    end
    mag_on = 1'b0;
  endtask

  // 0:30 counting to 0:17, async clear, zero start, then boundary digits 9 and 10.
  task automatic test_mid_clear();
    exp_t        e;
    logic        async;
    logic [11:0] t;
    logic        d, b;
    for (int i = 0; i < 61; i++) begin
      async = (i == 57);
      load = 1'b0; mag_on = 1'b0; digit = 4'd0; d = 1'b0; b = 1'b0; t = 12'h000;
      if (i < 3) begin
        load  = 1'b1;
        digit = (i == 1) ? 4'd3 : 4'd0;
        t     = (i == 0) ? 12'h070 : (i == 1) ? 12'h703 : 12'h030;
      end else if (i < 57) begin
        mag_on = 1'b1;
        t      = to_bcd(30 - (i - 3) / CPS);
      end else if (i == 58) begin
        mag_on = 1'b1; d = 1'b1; b = BEEP_ON;
      end else if (i == 59) begin
        load = 1'b1; digit = 4'd9; t = 12'h009;
      end else if (i == 60) begin
        load = 1'b1; digit = 4'd10; t = 12'h009;
      end
      sb.push_back(mk(i, t, d, b));
      if (async) begin
        mag_on = 1'b1;
        clearn = 1'b0;
        #2;
      end else begin
        tick();
      end
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL mid_clear step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
      if (async) begin
        tick();
        clearn = 1'b1;
      end
    end
    mag_on = 1'b0;
  endtask

  // 0:01 to DONE with beep window, exit and re-enter, then async clear mid-beep.
  task automatic test_beep();
    exp_t        e;
    logic        async;
    logic [11:0] t;
    logic        d, b;
    int          k;
    for (int i = 0; i < 17; i++) begin
      async = (i == 16);
      load = 1'b0; mag_on = 1'b0; digit = 4'd0; d = 1'b0; b = 1'b0; t = 12'h000;
      if (i < 3) begin
        load  = 1'b1;
        digit = (i == 2) ? 4'd1 : 4'd0;
        t     = (i == 0) ? 12'h090 : (i == 1) ? 12'h900 : 12'h001;
      end else if (i < 14) begin
        k = i - 3;
        mag_on = 1'b1;
        t = (k < CPS) ? 12'h001 : 12'h000;
        d = (k >= CPS);
        b = BEEP_ON && k >= CPS && k < CPS + BC;
      end else if (i == 14) begin
        load = 1'b1;
      end else if (i == 15) begin
        mag_on = 1'b1; d = 1'b1; b = BEEP_ON;
      end
      sb.push_back(mk(i, t, d, b));
      if (async) begin
        clearn = 1'b0;
        #2;
      end else begin
        tick();
      end
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL beep step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
      if (async) begin
        mag_on = 1'b0;
        tick();
        clearn = 1'b1;
      end
    end
  endtask

  // 0:90 counts down through 0:89 like any other value.
  task automatic test_nonstd();
    exp_t        e;
    logic [11:0] t;
    int          v;
    for (int i = 0; i < 15; i++) begin
      load = 1'b0; mag_on = 1'b0; digit = 4'd0;
      if (i < 2) begin
        load  = 1'b1;
        digit = (i == 0) ? 4'd9 : 4'd0;
        t     = (i == 0) ? 12'h009 : 12'h090;
      end else begin
        mag_on = 1'b1;
        v = 90 - (i - 2) / CPS;
        t = {4'd0, 4'(v / 10), 4'(v % 10)};
      end
      sb.push_back(mk(i, t, 1'b0, 1'b0));
      tick();
      load = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if ({min_ones, sec_tens, sec_ones} !== e.t || timer_done !== e.done || beep !== e.bp)
        $display("FAIL nonstd step %0d: got %h%h%h done=%b beep=%b, expected %h done=%b beep=%b",
                 e.step, min_ones, sec_tens, sec_ones, timer_done, beep, e.t, e.done, e.bp);
      else n_pass++;
    end
    mag_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_pause();
    test_zero_start();
    test_mid_clear();
    test_beep();
    test_nonstd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
